// File: rtl/stopwatch_core.sv
// Stopwatch core: debounced run/clear buttons drive an IDLE/RUN/PAUSE FSM and a BCD time counter.
// Latency: a button event acts about 2 + DB cycles after a clean raw edge; display updates the cycle after a tick.
// Backpressure: none; free-running block, outputs are always valid registers.

// One button: 2-flop synchronizer, level debouncer and rising-edge press detector.
module stopwatch_core_btn #(
    parameter int DB_CYCLES = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw_i,
    output logic press_o
);
    localparam int DB_EFF = (DB_CYCLES < 1) ? 1 : DB_CYCLES;
    localparam int CW     = (DB_EFF < 2) ? 1 : $clog2(DB_EFF);
    localparam logic [CW-1:0] CNT_TERM = CW'(DB_EFF - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          prev_q;
    logic          armed_q, armed_d;

    // Synchronizer, debouncer and edge-detect state; everything reads as released after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 2'b00;
            fill_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw_i};
            fill_q  <= {fill_q[0], 1'b1};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            armed_q <= armed_d;
        end
    end

    // Accept a new level only after it differs from the current one for DB_EFF consecutive cycles.
    // Presses are armed only once the synchronized button has been seen released after reset,
    // so a button held through reset never produces an event until pressed again.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_TERM) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        armed_d = armed_q | (fill_q[1] & ~sync_q[1]);
    end

    assign press_o = level_q & ~prev_q & armed_q;
endmodule

// Top level stopwatch.
module stopwatch_core #(
    parameter int CLOCK_FREQ  = 100000000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_run,
    input  logic        btn_clear,
    output logic [31:0] display,
    output logic [7:0]  digit_enable,
    output logic        running,
    output logic        overflow
);
    localparam int DB_CYCLES = (CLOCK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int PRE_MAX   = (CLOCK_FREQ / 100 > 1) ? (CLOCK_FREQ / 100 - 1) : 0;
    localparam int PW        = (PRE_MAX < 1) ? 1 : $clog2(PRE_MAX + 1);
    localparam logic [PW-1:0] PRE_TERM = PW'(PRE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   time_q, time_d;
    logic [31:0]   time_inc;
    logic          inc_carry;
    logic          tick;
    logic          overflow_q, overflow_d;
    logic          running_q;
    logic [7:0]    de_q;
    logic          run_ev;
    logic          clr_ev;

    stopwatch_core_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_run (
        .clk       (clk),
        .resetn    (resetn),
        .btn_raw_i (btn_run),
        .press_o   (run_ev)
    );

    stopwatch_core_btn #(.DB_CYCLES(DB_CYCLES)) u_btn_clear (
        .clk       (clk),
        .resetn    (resetn),
        .btn_raw_i (btn_clear),
        .press_o   (clr_ev)
    );

    // BCD +0.01 s with ripple carry; d3/d5 wrap at 5, the rest at 9. Out-of-range digits also wrap.
    always_comb begin
        time_inc  = time_q;
        inc_carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (inc_carry) begin
                if (time_q[4*i +: 4] >= ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
                    time_inc[4*i +: 4] = 4'd0;
                end else begin
                    time_inc[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
                    inc_carry          = 1'b0;
                end
            end
        end
    end

    // FSM next state, prescaler and time update; clear overrides everything else in the same cycle.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        time_d     = time_q;
        overflow_d = 1'b0;
        tick       = (state_q == RUN) && (pre_q == PRE_TERM);

        case (state_q)
            IDLE:    pre_d = '0;
            RUN:     pre_d = tick ? '0 : pre_q + 1'b1;
            PAUSE:   pre_d = pre_q;
            default: pre_d = '0;
        endcase

        if (tick) begin
            time_d     = time_inc;
            overflow_d = inc_carry;
        end

        if (run_ev) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if (clr_ev) begin
            state_d    = IDLE;
            pre_d      = '0;
            time_d     = '0;
            overflow_d = 1'b0;
        end
    end

    // State, count and registered output decodes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            time_q     <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
            de_q       <= 8'h3F;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            time_q     <= time_d;
            overflow_q <= overflow_d;
            running_q  <= (state_d == RUN);
            de_q       <= {{2{|time_d[31:24]}}, 6'h3F};
        end
    end

    assign display      = time_q;
    assign digit_enable = de_q;
    assign running      = running_q;
    assign overflow     = overflow_q;
endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 100000000, clk frequency in Hz.
REQ-002 The block SHALL have parameter DEBOUNCE_MS, default 10, button stability window in ms.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port btn_run  input  1  raw start/stop pushbutton, active-high, asynchronous to clk.
REQ-006 The block SHALL have port btn_clear  input  1  raw clear pushbutton, active-high, asynchronous to clk.
REQ-007 The block SHALL have port display  output  32  eight BCD digits for the downstream 7-seg driver, 4 bits per digit, digit 0 in [3:0].
REQ-008 The block SHALL have port digit_enable  output  8  per-digit enable bitmap, bit n gates digit n.
REQ-009 The block SHALL have port running  output  1  high while state is RUN.
REQ-010 The block SHALL have port overflow  output  1  one-cycle pulse on wrap from 99:59:59.99.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after it holds DB = (CLOCK_FREQ/1000)*DEBOUNCE_MS consecutive cycles.
REQ-012 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; release generates no event.
REQ-013 Press event latency SHALL be 2 + DB cycles (±1) from a clean raw rising edge.
REQ-014 Digit map SHALL be: d0 hundredths units, d1 hundredths tens, d2 s units, d3 s tens (0-5), d4 min units, d5 min tens (0-5), d6 h units, d7 h tens.
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE; run event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 A clear event in any state SHALL zero all digits and the prescaler and enter IDLE on the next cycle.
REQ-017 A clear event and a run event in the same cycle SHALL act as clear only (result IDLE, all zero).
REQ-018 A prescaler SHALL count 0..(CLOCK_FREQ/100 - 1) only in RUN, emitting a tick on terminal count, then wrap to 0.
REQ-019 The prescaler SHALL hold its value in PAUSE, so resume keeps the 10 ms phase, and SHALL be 0 in IDLE.
REQ-020 Each tick SHALL increment the BCD time by 0.01 s with ripple carry: d0,d1,d2,d4,d6,d7 wrap 9->0; d3,d5 wrap 5->0.
REQ-021 Digits SHALL never hold values above their limit (d0-d2,d4,d6,d7 <= 9; d3,d5 <= 5).
REQ-022 On tick at 99:59:59.99, time SHALL become 00:00:00.00, overflow SHALL pulse for exactly that cycle, and state SHALL stay RUN.
REQ-023 display SHALL be registered and reflect the new count the cycle after the tick.
REQ-024 digit_enable[5:0] SHALL always be 1.
REQ-025 digit_enable[7:6] SHALL be 2'b11 when the hours value is non-zero, else 2'b00 (leading hours blanked).
REQ-026 running SHALL be a registered decode of state == RUN.

Reset
REQ-027 resetn low SHALL immediately (asynchronously) force state IDLE, all digits 0, display 0, prescaler 0, running 0, overflow 0, digit_enable 8'h3F.
REQ-028 resetn low SHALL also clear synchronizer and debouncer state to released (0).
REQ-029 After resetn rises, an already-held button SHALL NOT produce an event until it is released and pressed again.
REQ-030 Reset asserted mid-RUN SHALL discard the count with no overflow pulse.

Verification (CLOCK_FREQ=1000, DEBOUNCE_MS=2: tick every 10 cycles, DB=2)
REQ-031 Reset release, no buttons, 1000 cycles -> display 0, digit_enable 8'h3F, running 0.
REQ-032 Press btn_run, hold 10 cycles, wait 1000 ticks -> running 1, display 32'h0000_1000 (10.00 s).
REQ-033 Bounce btn_run 1-cycle glitches for 20 cycles, then settle high -> exactly one event, state RUN.
REQ-034 Run, pause at 5 cycles into a tick period, wait 100 cycles, resume -> next increment 5 cycles after resume, count frozen during PAUSE.
REQ-035 Force-load 32'h9959_5999 while RUN, one tick -> display 0, overflow high 1 cycle, running stays 1, digit_enable 8'h3F.
REQ-036 Debounced run and clear pressed in the same cycle while RUN at 32'h0100_0000 -> display 0, IDLE, digit_enable 8'h3F; separately, resetn pulse mid-RUN -> all outputs at reset values asynchronously.
